fifo_ctrl_burst: RTL and testbench

//  Parametrised FIFO controller: pointer/flag generator for the FIFO reg_file,

---
 rtl/fifo_ctrl_burst.sv | 119 +++++++++++
 tb/tb_fifo_ctrl_burst.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_burst.sv
// Pointer, occupancy and flag generator for a FIFO register file.
// STANDARD mode: independent reads and writes. BURST mode: fill to full, then drain to empty.
module fifo_ctrl_burst #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2,
    parameter int BURST_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic                  clear_err,
    output logic                  rd_ack,
    output logic                  wr_ack,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  draining,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_DRAIN = 1'b1
    } phase_t;

    phase_t                phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  is_empty, is_full;
    logic                  ovf_set, unf_set;

    // Flags come only from the registered count, never from rd/wr directly.
    assign is_empty     = (count_q == '0);
    assign is_full      = (count_q == DEPTH_C);
    assign empty        = is_empty;
    assign full         = is_full;
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign draining     = (phase_q == PH_DRAIN);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign w_addr       = wr_ptr_q;
    assign r_addr       = rd_ptr_q;

    always_comb begin
        rd_ack  = 1'b0;
        wr_ack  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        phase_d = phase_q;

        if (BURST_MODE != 0) begin
            // Requests blocked by the current phase are not counted as errors.
            if (phase_q == PH_FILL) begin
                wr_ack  = wr & ~is_full;
                ovf_set = wr & is_full;
            end else begin
                rd_ack  = rd & ~is_empty;
                unf_set = rd & is_empty;
            end
        end else begin
            rd_ack  = rd & ~is_empty;
            wr_ack  = wr & (~is_full | rd);
            ovf_set = wr & is_full & ~wr_ack;
            unf_set = rd & is_empty;
        end

        count_d  = count_q + (ADDR_WIDTH + 1)'(wr_ack) - (ADDR_WIDTH + 1)'(rd_ack);
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_ack);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(rd_ack);

        if (BURST_MODE != 0) begin
            case (phase_q)
                PH_FILL:  if (count_d == DEPTH_C) phase_d = PH_DRAIN;
                PH_DRAIN: if (count_d == '0)      phase_d = PH_FILL;
                default:  phase_d = PH_FILL;
            endcase
        end

        // A new error in the same cycle as clear_err wins.
        overflow_d  = (overflow_q  & ~clear_err) | ovf_set;
        underflow_d = (underflow_q & ~clear_err) | unf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_burst.sv
// Bench for fifo_ctrl_burst: one STANDARD and one BURST instance, each tracked by a
// behavioural occupancy/phase model; directed scenarios followed by random traffic.
module tb_fifo_ctrl_burst;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic clk;
    logic reset_i [2];
    logic rd_i    [2];
    logic wr_i    [2];
    logic clr_i   [2];
    logic rd_ack_o[2];
    logic wr_ack_o[2];
    logic empty_o [2];
    logic full_o  [2];
    logic ae_o    [2];
    logic af_o    [2];
    logic [AW:0] count_o[2];
    logic drain_o [2];
    logic ovf_o   [2];
    logic unf_o   [2];
    logic [AW-1:0] waddr_o[2];
    logic [AW-1:0] raddr_o[2];

    // Reference model state, index 0 = STANDARD, 1 = BURST
    int m_count[2];
    int m_wp   [2];
    int m_rp   [2];
    bit m_drain[2];
    bit m_ovf  [2];
    bit m_unf  [2];

    int total;
    int bad;

    fifo_ctrl_burst #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .BURST_MODE(0)) u_std (
        .clk(clk), .reset(reset_i[0]), .rd(rd_i[0]), .wr(wr_i[0]), .clear_err(clr_i[0]),
        .rd_ack(rd_ack_o[0]), .wr_ack(wr_ack_o[0]), .empty(empty_o[0]), .full(full_o[0]),
        .almost_empty(ae_o[0]), .almost_full(af_o[0]), .count(count_o[0]),
        .draining(drain_o[0]), .overflow(ovf_o[0]), .underflow(unf_o[0]),
        .w_addr(waddr_o[0]), .r_addr(raddr_o[0])
    );

    fifo_ctrl_burst #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .BURST_MODE(1)) u_bst (
        .clk(clk), .reset(reset_i[1]), .rd(rd_i[1]), .wr(wr_i[1]), .clear_err(clr_i[1]),
        .rd_ack(rd_ack_o[1]), .wr_ack(wr_ack_o[1]), .empty(empty_o[1]), .full(full_o[1]),
        .almost_empty(ae_o[1]), .almost_full(af_o[1]), .count(count_o[1]),
        .draining(drain_o[1]), .overflow(ovf_o[1]), .underflow(unf_o[1]),
        .w_addr(waddr_o[1]), .r_addr(raddr_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_count[d] = 0;
        m_wp[d]    = 0;
        m_rp[d]    = 0;
        m_drain[d] = 0;
        m_ovf[d]   = 0;
        m_unf[d]   = 0;
    endtask

    task automatic check_state(input int d);
        string p;
        p = (d == 0) ? "std" : "bst";
        chk({p, "_count"}, count_o[d], m_count[d]);
        chk({p, "_empty"}, empty_o[d], m_count[d] == 0);
        chk({p, "_full"},  full_o[d],  m_count[d] == DEPTH);
        chk({p, "_aempty"}, ae_o[d], m_count[d] <= AE);
        chk({p, "_afull"},  af_o[d], m_count[d] >= AF);
        chk({p, "_draining"}, drain_o[d], m_drain[d]);
        chk({p, "_overflow"}, ovf_o[d], m_ovf[d]);
        chk({p, "_underflow"}, unf_o[d], m_unf[d]);
        chk({p, "_w_addr"}, waddr_o[d], m_wp[d]);
        chk({p, "_r_addr"}, raddr_o[d], m_rp[d]);
    endtask

    // One clock with the given requests on DUT d; the other DUT idles.
    task automatic cycle(input int d, input bit rd, input bit wr, input bit clr);
        bit ra, wa;
        string p;
        p = (d == 0) ? "std" : "bst";
        rd_i[d]  = rd;
        wr_i[d]  = wr;
        clr_i[d] = clr;
        if (d == 0) begin
            ra = rd && (m_count[0] > 0);
            wa = wr && (m_count[0] - int'(ra) < DEPTH);
        end else if (!m_drain[1]) begin
            ra = 0;
            wa = wr && (m_count[1] < DEPTH);
        end else begin
            wa = 0;
            ra = rd && (m_count[1] > 0);
        end
        #2;
        chk({p, "_rd_ack"}, rd_ack_o[d], ra);
        chk({p, "_wr_ack"}, wr_ack_o[d], wa);
        @(posedge clk);
        #1;
        if (clr) begin
            m_ovf[d] = 0;
            m_unf[d] = 0;
        end
        if (d == 0 || !m_drain[d]) begin
            if (wr && !wa && (d == 0 || m_count[d] == DEPTH)) m_ovf[d] = 1;
        end
        if (d == 0 || m_drain[d]) begin
            if (rd && !ra) m_unf[d] = 1;
        end
        m_count[d] = m_count[d] + int'(wa) - int'(ra);
        m_wp[d]    = (m_wp[d] + int'(wa)) % DEPTH;
        m_rp[d]    = (m_rp[d] + int'(ra)) % DEPTH;
        if (d == 1) begin
            if (!m_drain[1] && m_count[1] == DEPTH) m_drain[1] = 1;
            else if (m_drain[1] && m_count[1] == 0) m_drain[1] = 0;
        end
        rd_i[d]  = 0;
        wr_i[d]  = 0;
        clr_i[d] = 0;
        $display("txn %s rd=%0b wr=%0b clr=%0b ra=%0b wa=%0b count=%0d", p, rd, wr, clr, ra, wa, m_count[d]);
        check_state(d);
    endtask

    task automatic do_reset(input int d);
        reset_i[d] = 1;
        @(posedge clk);
        #1;
        reset_i[d] = 0;
        model_reset(d);
        $display("txn %s reset", (d == 0) ? "std" : "bst");
        check_state(d);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int d = 0; d < 2; d++) begin
            reset_i[d] = 1;
            rd_i[d]    = 0;
            wr_i[d]    = 0;
            clr_i[d]   = 0;
            model_reset(d);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_i[0] = 0;
        reset_i[1] = 0;
        check_state(0);
        check_state(1);
        chk("reset_empty_const", empty_o[0], 1);

        // STANDARD: fill to full, pointer wraps
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 0);
        chk("std_full_count", count_o[0], 16);
        chk("std_waddr_wrap", waddr_o[0], 0);
        // full with simultaneous rd/wr
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0);
        chk("std_rw_raddr", raddr_o[0], 5);
        chk("std_rw_waddr", waddr_o[0], 5);
        // overflow
        cycle(0, 0, 1, 0);
        chk("std_overflow_set", ovf_o[0], 1);
        cycle(0, 0, 0, 1);
        // drain and underflow
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("std_underflow_set", unf_o[0], 1);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 1);
        chk("std_set_beats_clear", unf_o[0], 1);
        cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 1);

        // BURST: rd in FILL ignored, fill, wr in DRAIN ignored, drain
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);
        cycle(1, 1, 0, 0);
        chk("bst_fill_no_underflow", unf_o[1], 0);
        for (int i = 0; i < 13; i++) cycle(1, 0, 1, 0);
        chk("bst_draining", drain_o[1], 1);
        cycle(1, 0, 1, 0);
        chk("bst_drain_no_overflow", ovf_o[1], 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, 0);
        chk("bst_back_to_fill", drain_o[1], 0);
        // reset mid-drain at count 9
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 1, 0);
        for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0);
        chk("bst_mid_drain_count", count_o[1], 9);
        do_reset(1);

        // random traffic on both modes
        for (int i = 0; i < 300; i++)
            cycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0 ? ($urandom_range(0, 1) == 1) : 1'b1,
                  $urandom_range(0, 15) == 0);
        for (int i = 0; i < 300; i++)
            cycle(1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        do_reset(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
